// File: rtl/lot_gate_controller.sv
// Parking lot gate controller.
// Tracks the outer (A) and inner (B) photo-sensors through the entry and exit
// beam-break sequences, keeps a saturating occupancy count, and flags illegal,
// stalled, overfull or underflowing sequences with a one-cycle seq_error.
module lot_gate_controller #(
  parameter int CAPACITY  = 15,
  parameter int CNT_WIDTH = 4,
  parameter int TMO_WIDTH = 28
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sensor_a,
  input  logic                 sensor_b,
  output logic                 enter_pulse,
  output logic                 exit_pulse,
  output logic                 seq_error,
  output logic [CNT_WIDTH-1:0] occupancy,
  output logic                 full,
  output logic                 empty
);

  typedef enum logic [2:0] {
    IDLE, EN_A, EN_AB, EN_B, EX_B, EX_AB, EX_A, ERR
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CAP      = CNT_WIDTH'(CAPACITY);
  // The counter "reaches" all-ones on the hold that would load all-ones,
  // so the stall limit is one below all-ones.
  localparam logic [TMO_WIDTH-1:0] TMO_LAST = ~TMO_WIDTH'(1);

  state_t               state, state_dec, state_nx;
  logic [TMO_WIDTH-1:0] tmo_cnt, tmo_nx;
  logic [CNT_WIDTH-1:0] occ_nx;
  logic                 enter_nx, exit_nx, err_nx;
  logic [1:0]           ab;

  assign ab = {sensor_a, sensor_b};

  // Decode the sensor pattern into the next sequence state, then apply the
  // stall timeout and the count/pulse consequences of completed sequences.
  always_comb begin
    state_dec = ERR;
    state_nx  = state;
    tmo_nx    = '0;
    occ_nx    = occupancy;
    enter_nx  = 1'b0;
    exit_nx   = 1'b0;
    err_nx    = 1'b0;

    unique case (state)
      IDLE:  case (ab)
               2'b00:   state_dec = IDLE;
               2'b10:   state_dec = EN_A;
               2'b01:   state_dec = EX_B;
               default: state_dec = ERR;
             endcase
      EN_A:  case (ab)
               2'b10:   state_dec = EN_A;
               2'b11:   state_dec = EN_AB;
               2'b00:   state_dec = IDLE;
               default: state_dec = ERR;
             endcase
      EN_AB: case (ab)
               2'b11:   state_dec = EN_AB;
               2'b01:   state_dec = EN_B;
               2'b10:   state_dec = EN_A;
               default: state_dec = ERR;
             endcase
      EN_B:  case (ab)
               2'b01:   state_dec = EN_B;
               2'b11:   state_dec = EN_AB;
               2'b00:   state_dec = IDLE;
               default: state_dec = ERR;
             endcase
      EX_B:  case (ab)
               2'b01:   state_dec = EX_B;
               2'b11:   state_dec = EX_AB;
               2'b00:   state_dec = IDLE;
               default: state_dec = ERR;
             endcase
      EX_AB: case (ab)
               2'b11:   state_dec = EX_AB;
               2'b10:   state_dec = EX_A;
               2'b01:   state_dec = EX_B;
               default: state_dec = ERR;
             endcase
      EX_A:  case (ab)
               2'b10:   state_dec = EX_A;
               2'b11:   state_dec = EX_AB;
               2'b00:   state_dec = IDLE;
               default: state_dec = ERR;
             endcase
      ERR:   state_dec = (ab == 2'b00) ? IDLE : ERR;
      default: state_dec = ERR;
    endcase

    state_nx = state_dec;

    if (state_dec == state) begin
      // Holding: only the in-sequence states age toward a stall timeout.
      if (state != IDLE && state != ERR) begin
        if (tmo_cnt == TMO_LAST) begin
          state_nx = ERR;
          err_nx   = 1'b1;
        end else begin
          tmo_nx = tmo_cnt + 1'b1;
        end
      end
    end else if (state_dec == ERR) begin
      err_nx = 1'b1;
    end else if (state == EN_B && state_dec == IDLE) begin
      if (occupancy < CAP) begin
        occ_nx   = occupancy + 1'b1;
        enter_nx = 1'b1;
      end else begin
        err_nx = 1'b1;
      end
    end else if (state == EX_A && state_dec == IDLE) begin
      if (occupancy != '0) begin
        occ_nx  = occupancy - 1'b1;
        exit_nx = 1'b1;
      end else begin
        err_nx = 1'b1;
      end
    end
  end

  // Register state, stall counter, count and pulses; reset drops any partial sequence.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      occupancy   <= '0;
      enter_pulse <= 1'b0;
      exit_pulse  <= 1'b0;
      seq_error   <= 1'b0;
    end else begin
      state       <= state_nx;
      tmo_cnt     <= tmo_nx;
      occupancy   <= occ_nx;
      enter_pulse <= enter_nx;
      exit_pulse  <= exit_nx;
      seq_error   <= err_nx;
    end
  end

  assign full  = (occupancy == CAP);
  assign empty = (occupancy == '0);

endmodule

// File: tb/tb_lot_gate_controller.sv
// Testbench for lot_gate_controller: directed sensor sequences push expected
// pulse events into a queue; a monitor pops and compares them whenever the
// DUT raises any pulse.
module tb_lot_gate_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       sensor_a, sensor_b;
  logic       enter_pulse, exit_pulse, seq_error;
  logic [3:0] occupancy;
  logic       full, empty;

  int check_count = 0;
  int pass_count  = 0;
  int occ_model   = 0;

  typedef struct {
    logic       enter;
    logic       exit_;
    logic       err;
    logic [3:0] occ;
  } ev_t;

  ev_t exp_q[$];

  lot_gate_controller #(.CAPACITY(15), .CNT_WIDTH(4), .TMO_WIDTH(6)) dut (
    .clk(clk), .reset(reset), .sensor_a(sensor_a), .sensor_b(sensor_b),
    .enter_pulse(enter_pulse), .exit_pulse(exit_pulse), .seq_error(seq_error),
    .occupancy(occupancy), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
  endtask

  // Packs pulses, flags and count in one word: {enter, exit, err, full, empty, occ}.
  function automatic logic [31:0] pack_ev(input ev_t e);
    return {23'd0, e.enter, e.exit_, e.err, (e.occ == 4'd15), (e.occ == 4'd0), e.occ};
  endfunction

  // Monitor: whenever any pulse appears, compare it against the oldest expectation.
  always @(negedge clk) begin
    if (!reset && (enter_pulse || exit_pulse || seq_error)) begin
      ev_t act;
      act.enter = enter_pulse;
      act.exit_ = exit_pulse;
      act.err   = seq_error;
      act.occ   = occupancy;
      if (exp_q.size() == 0) begin
        check_output("unexpected_pulse", pack_ev(act), 32'd0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check_output("pulse_event", {23'd0, enter_pulse, exit_pulse, seq_error,
                                     full, empty, occupancy}, pack_ev(e));
      end
    end
  end

  task automatic apply_stimulus(input logic [1:0] ab, input int n);
    sensor_a = ab[1];
    sensor_b = ab[0];
    repeat (n) @(negedge clk);
  endtask

  task automatic push_ev(input logic en, input logic ex, input logic er);
    ev_t e;
    e.enter = en;
    e.exit_ = ex;
    e.err   = er;
    e.occ   = 4'(occ_model);
    exp_q.push_back(e);
  endtask

  task automatic do_entry(input int n);
    if (occ_model < 15) begin
      occ_model++;
      push_ev(1'b1, 1'b0, 1'b0);
    end else begin
      push_ev(1'b0, 1'b0, 1'b1);
    end
    apply_stimulus(2'b00, n);
    apply_stimulus(2'b10, n);
    apply_stimulus(2'b11, n);
    apply_stimulus(2'b01, n);
    apply_stimulus(2'b00, n);
  endtask

  task automatic do_exit(input int n);
    if (occ_model > 0) begin
      occ_model--;
      push_ev(1'b0, 1'b1, 1'b0);
    end else begin
      push_ev(1'b0, 1'b0, 1'b1);
    end
    apply_stimulus(2'b00, n);
    apply_stimulus(2'b01, n);
    apply_stimulus(2'b11, n);
    apply_stimulus(2'b10, n);
    apply_stimulus(2'b00, n);
  endtask

  // Waits a bounded time for all expected events, then checks none are missing.
  task automatic drain(input string name);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check_output(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_count_state(input string name);
    check_output({name, "_occ"}, occupancy, occ_model);
    check_output({name, "_full"}, full, (occ_model == 15));
    check_output({name, "_empty"}, empty, (occ_model == 0));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    sensor_a = 1'b0;
    sensor_b = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_pulses", {enter_pulse, exit_pulse, seq_error}, 3'b000);
    check_count_state("reset");
    reset = 1'b0;
    apply_stimulus(2'b00, 2);

    // Entry with each pattern held three cycles.
    do_entry(3);
    drain("entry_drain");
    check_count_state("after_entry");

    // Second entry, two exits, then an exit with nobody inside.
    do_entry(2);
    do_exit(2);
    drain("exit_drain");
    check_count_state("after_exit");
    do_exit(2);
    do_exit(2);
    drain("underflow_drain");
    check_count_state("after_underflow");

    // Back-outs produce nothing; a reversal mid-entry still counts once.
    apply_stimulus(2'b10, 3);
    apply_stimulus(2'b00, 3);
    apply_stimulus(2'b01, 3);
    apply_stimulus(2'b00, 3);
    drain("backout_drain");
    occ_model++;
    push_ev(1'b1, 1'b0, 1'b0);
    apply_stimulus(2'b10, 2);
    apply_stimulus(2'b11, 2);
    apply_stimulus(2'b10, 2);
    apply_stimulus(2'b11, 2);
    apply_stimulus(2'b01, 2);
    apply_stimulus(2'b00, 3);
    drain("reversal_drain");
    check_count_state("after_reversal");

    // Illegal jump from IDLE held: one error, then recovery and a valid entry.
    push_ev(1'b0, 1'b0, 1'b1);
    apply_stimulus(2'b11, 5);
    apply_stimulus(2'b00, 3);
    do_entry(2);
    drain("jump_drain");
    check_count_state("after_jump");

    // Fill to capacity, then one more entry is refused.
    while (occ_model < 15) do_entry(1);
    drain("fill_drain");
    check_count_state("full");
    do_entry(1);
    drain("overfull_drain");
    check_count_state("after_overfull");

    // A long but sub-limit hold is fine; an over-limit hold errors once.
    apply_stimulus(2'b10, 50);
    apply_stimulus(2'b00, 3);
    drain("short_hold_drain");
    push_ev(1'b0, 1'b0, 1'b1);
    apply_stimulus(2'b10, 70);
    apply_stimulus(2'b00, 3);
    drain("timeout_drain");
    check_count_state("after_timeout");

    // Reset while at EN_AB: counts clear and the partial entry is forgotten,
    // so the following 01,00 is an exit back-out rather than an entry.
    apply_stimulus(2'b10, 2);
    apply_stimulus(2'b11, 2);
    #2 reset = 1'b1;
    #1;
    occ_model = 0;
    check_output("async_reset_pulses", {enter_pulse, exit_pulse, seq_error}, 3'b000);
    check_count_state("async_reset");
    @(negedge clk);
    reset = 1'b0;
    apply_stimulus(2'b01, 3);
    apply_stimulus(2'b00, 3);
    drain("post_reset_drain");
    check_count_state("post_reset");

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
